ysyx_23060075_wbu: RTL

Write-back unit of the NPC core. Accepts one retiring instruction at a time from the execute stage over a valid/ready handshake. For loads, it waits for the load-store unit's read response and sign- or zero-extends the selected byte or halfword. It then drives the single write port of the general-purpose register file and emits a one-cycle commit pulse with the instruction's PC.

---
 rtl/ysyx_23060075_wbu_pkg.sv | 20 ++
 rtl/ysyx_23060075_load_ext.sv | 34 +++
 rtl/ysyx_23060075_wbu.sv | 117 +++++++++++
 3 files changed

// File: rtl/ysyx_23060075_wbu_pkg.sv
// Shared widths, FSM state encoding and load funct3 codes for the write-back unit,
// the LSU and the decoder.
package ysyx_23060075_wbu_pkg;

  localparam int ISA_WIDTH      = 32;
  localparam int REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    WBU_IDLE     = 2'b00,
    WBU_WAIT_LSU = 2'b01,
    WBU_WRITE    = 2'b10
  } wbu_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/ysyx_23060075_load_ext.sv
// Combinational load-data extraction: selects byte/halfword/word from an aligned
// word and sign/zero-extends it; flags misaligned or unknown load types.
module ysyx_23060075_load_ext
  import ysyx_23060075_wbu_pkg::*;
#(
  parameter int ISA_WIDTH = ysyx_23060075_wbu_pkg::ISA_WIDTH
) (
  input  logic [ISA_WIDTH-1:0] rdata,
  input  logic [2:0]           funct3,
  input  logic [1:0]           addr_lo,
  output logic [ISA_WIDTH-1:0] ext,
  output logic                 err
);

  logic [ISA_WIDTH-1:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    ext     = '0;
    err     = 1'b0;
    case (funct3)
      F3_LB:  ext = {{(ISA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LBU: ext = {{(ISA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LH:  if (addr_lo[0]) err = 1'b1;
              else ext = {{(ISA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LHU: if (addr_lo[0]) err = 1'b1;
              else ext = {{(ISA_WIDTH-16){1'b0}}, shifted[15:0]};
      F3_LW:  if (addr_lo != 2'b00) err = 1'b1;
              else ext = rdata;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_23060075_wbu.sv
// Write-back unit: accepts one retiring instruction, waits for load data when
// needed, then drives the GPR write port and a one-cycle commit pulse.
module ysyx_23060075_wbu
  import ysyx_23060075_wbu_pkg::*;
#(
  parameter int ISA_WIDTH      = ysyx_23060075_wbu_pkg::ISA_WIDTH,
  parameter int REG_ADDR_WIDTH = ysyx_23060075_wbu_pkg::REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      exu_valid,
  output logic                      exu_ready,
  input  logic [ISA_WIDTH-1:0]      exu_pc,
  input  logic [ISA_WIDTH-1:0]      exu_result,
  input  logic [REG_ADDR_WIDTH-1:0] exu_rd,
  input  logic                      exu_rd_wen,
  input  logic                      exu_is_load,
  input  logic [2:0]                exu_funct3,
  input  logic [1:0]                exu_addr_lo,
  input  logic                      lsu_rvalid,
  input  logic [ISA_WIDTH-1:0]      lsu_rdata,
  output logic                      lsu_rready,
  output logic [ISA_WIDTH-1:0]      gpr_w,
  output logic [REG_ADDR_WIDTH-1:0] gpr_w_addr,
  output logic                      gpr_w_en,
  output logic                      commit_valid,
  output logic [ISA_WIDTH-1:0]      commit_pc,
  output logic                      load_err
);

  wbu_state_e state, state_nxt;

  logic [ISA_WIDTH-1:0]      pc_p1;
  logic [ISA_WIDTH-1:0]      result_p1;
  logic [REG_ADDR_WIDTH-1:0] rd_p1;
  logic                      rd_wen_p1;
  logic [2:0]                funct3_p1;
  logic [1:0]                addr_lo_p1;
  logic                      err_p1;

  logic [ISA_WIDTH-1:0]      ext_val;
  logic                      ext_err;

  logic accept;
  logic lsu_take;

  assign accept   = (state == WBU_IDLE) && exu_valid;
  assign lsu_take = (state == WBU_WAIT_LSU) && lsu_rvalid;

  ysyx_23060075_load_ext #(
    .ISA_WIDTH (ISA_WIDTH)
  ) u_load_ext (
    .rdata   (lsu_rdata),
    .funct3  (funct3_p1),
    .addr_lo (addr_lo_p1),
    .ext     (ext_val),
    .err     (ext_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= WBU_IDLE;
      err_p1 <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept)        err_p1 <= 1'b0;
      else if (lsu_take) err_p1 <= ext_err;
    end
  end

  // Payload latches: only observed through outputs gated by WRITE, so no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      pc_p1      <= exu_pc;
      result_p1  <= exu_result;
      rd_p1      <= exu_rd;
      rd_wen_p1  <= exu_rd_wen;
      funct3_p1  <= exu_funct3;
      addr_lo_p1 <= exu_addr_lo;
    end else if (lsu_take) begin
      result_p1 <= ext_val;
    end
  end

  always_comb begin
    state_nxt    = state;
    exu_ready    = 1'b0;
    lsu_rready   = 1'b0;
    gpr_w        = '0;
    gpr_w_addr   = '0;
    gpr_w_en     = 1'b0;
    commit_valid = 1'b0;
    commit_pc    = '0;
    load_err     = 1'b0;
    case (state)
      WBU_IDLE: begin
        exu_ready = 1'b1;
        if (exu_valid) state_nxt = exu_is_load ? WBU_WAIT_LSU : WBU_WRITE;
      end
      WBU_WAIT_LSU: begin
        lsu_rready = 1'b1;
        if (lsu_rvalid) state_nxt = WBU_WRITE;
      end
      WBU_WRITE: begin
        gpr_w        = result_p1;
        gpr_w_addr   = rd_p1;
        gpr_w_en     = rd_wen_p1;
        commit_valid = 1'b1;
        commit_pc    = pc_p1;
        load_err     = err_p1;
        state_nxt    = WBU_IDLE;
      end
      default: state_nxt = WBU_IDLE;
    endcase
  end

endmodule
